// File: rtl/sdio_arb_pkg.sv
// Shared types and register layout for the SDIO ownership arbiter.
// The state encoding is visible to software through STATUS[5:3].
package sdio_arb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_GUARD = 3'd1,
        ST_OWN   = 3'd2,
        ST_DRAIN = 3'd3
    } arb_state_t;

    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_SWCNT  = 2'd2;

    localparam int CTRL_FORCE_EN  = 0;
    localparam int CTRL_FORCE_SEL = 1;
    localparam int CTRL_GUARD_LSB = 8;
    localparam int CTRL_GUARD_MSB = 15;

    function automatic logic [1:0] onehot2(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/sdio_arb_apb_regs.sv
// APB slave for the arbiter: CTRL storage, switch counter and read mux.
// Zero-wait-state: the setup cycle registers pready and the read data.
module sdio_arb_apb_regs
    import sdio_arb_pkg::*;
#(
    parameter int GUARD_DEFAULT = 16,
    parameter int CNT_W         = 16
) (
    input  logic        pclk,
    input  logic        presetn,
    input  logic        psel,
    input  logic        penable,
    input  logic [31:0] paddr,
    input  logic        pwrite,
    input  logic [31:0] pwdata,
    output logic [31:0] prdata,
    output logic        pready,
    output logic        pslverr,
    output logic        force_en,
    output logic        force_sel,
    output logic [7:0]  guard,
    input  logic [1:0]  grant,
    input  logic        sdio_control,
    input  arb_state_t  state,
    input  logic        sdio_busy,
    input  logic [1:0]  req,
    input  logic        switch_strobe
);

    logic [CNT_W-1:0] sw_count;
    logic [31:0]      rd_data;
    logic [1:0]       reg_sel;
    logic             wr_en;
    logic             unused_bits;

    assign reg_sel     = paddr[3:2];
    assign wr_en       = psel && penable && pready && pwrite;
    assign pslverr     = psel && penable && (reg_sel == 2'd3);
    assign unused_bits = ^{paddr[31:4], paddr[1:0], pwdata[31:16], pwdata[7:2]};

    always_comb begin
        rd_data = '0;
        case (reg_sel)
            REG_CTRL: begin
                rd_data[CTRL_FORCE_EN]                  = force_en;
                rd_data[CTRL_FORCE_SEL]                 = force_sel;
                rd_data[CTRL_GUARD_MSB:CTRL_GUARD_LSB]  = guard;
            end
            REG_STATUS: rd_data[8:0]       = {req, sdio_busy, state, sdio_control, grant};
            REG_SWCNT:  rd_data[CNT_W-1:0] = sw_count;
            default:    rd_data            = '0;
        endcase
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            pready <= 1'b0;
            prdata <= '0;
        end else if (psel && !penable) begin
            pready <= 1'b1;
            prdata <= rd_data;
        end else begin
            pready <= 1'b0;
        end
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            force_en  <= 1'b0;
            force_sel <= 1'b0;
            guard     <= 8'(GUARD_DEFAULT);
        end else if (wr_en && reg_sel == REG_CTRL) begin
            force_en  <= pwdata[CTRL_FORCE_EN];
            force_sel <= pwdata[CTRL_FORCE_SEL];
            guard     <= pwdata[CTRL_GUARD_MSB:CTRL_GUARD_LSB];
        end
    end

    // A software clear takes priority over a switch landing in the same cycle.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            sw_count <= '0;
        end else if (wr_en && reg_sel == REG_SWCNT) begin
            sw_count <= '0;
        end else if (switch_strobe && sw_count != '1) begin
            sw_count <= sw_count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/sdio_owner_arbiter.sv
// Arbitrates the shared SDIO card interface between the MSS (req[0]) and the
// fabric crypto engine (req[1]) with break-before-make mux switching.
module sdio_owner_arbiter
    import sdio_arb_pkg::*;
#(
    parameter int GUARD_DEFAULT = 16,
    parameter int CNT_W         = 16
) (
    input  logic        pclk,
    input  logic        presetn,
    input  logic        psel,
    input  logic        penable,
    input  logic [31:0] paddr,
    input  logic        pwrite,
    input  logic [31:0] pwdata,
    output logic [31:0] prdata,
    output logic        pready,
    output logic        pslverr,
    input  logic [1:0]  req,
    input  logic        sdio_busy,
    output logic [1:0]  grant,
    output logic        SDIO_control,
    output logic        switch_pulse
);

    arb_state_t state, state_next;
    logic [7:0] guard_cnt, guard_cnt_next;
    logic [7:0] guard;
    logic [1:0] grant_next;
    logic       rr_last, rr_last_next;
    logic       owner, owner_next;
    logic       winner;
    logic       toggle;
    logic       force_en, force_sel;

    sdio_arb_apb_regs #(
        .GUARD_DEFAULT (GUARD_DEFAULT),
        .CNT_W         (CNT_W)
    ) u_regs (
        .pclk          (pclk),
        .presetn       (presetn),
        .psel          (psel),
        .penable       (penable),
        .paddr         (paddr),
        .pwrite        (pwrite),
        .pwdata        (pwdata),
        .prdata        (prdata),
        .pready        (pready),
        .pslverr       (pslverr),
        .force_en      (force_en),
        .force_sel     (force_sel),
        .guard         (guard),
        .grant         (grant),
        .sdio_control  (SDIO_control),
        .state         (state),
        .sdio_busy     (sdio_busy),
        .req           (req),
        .switch_strobe (toggle)
    );

    // Guard counter is loaded with guard-1 so the grant lands exactly guard+1
    // cycles after the toggle (grant is registered from the OWN state).
    always_comb begin
        state_next     = state;
        guard_cnt_next = guard_cnt;
        rr_last_next   = rr_last;
        owner_next     = owner;
        grant_next     = 2'b00;
        toggle         = 1'b0;
        winner         = (req == 2'b11) ? ~rr_last : req[1];

        case (state)
            ST_IDLE: begin
                if (force_en) begin
                    if (SDIO_control != force_sel && !sdio_busy) toggle = 1'b1;
                end else if (req != 2'b00 && !sdio_busy) begin
                    owner_next = winner;
                    if (winner == SDIO_control) begin
                        state_next = ST_OWN;
                    end else begin
                        toggle         = 1'b1;
                        guard_cnt_next = (guard == 8'd0) ? 8'd0 : guard - 8'd1;
                        state_next     = ST_GUARD;
                    end
                end
            end
            ST_GUARD: begin
                if (guard_cnt == 8'd0) begin
                    state_next = req[owner] ? ST_OWN : ST_IDLE;
                end else begin
                    guard_cnt_next = guard_cnt - 8'd1;
                end
            end
            ST_OWN: begin
                if (req[owner]) begin
                    grant_next = onehot2(owner);
                end else begin
                    rr_last_next = owner;
                    state_next   = sdio_busy ? ST_DRAIN : ST_IDLE;
                end
            end
            ST_DRAIN: begin
                if (!sdio_busy) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state        <= ST_IDLE;
            guard_cnt    <= 8'd0;
            rr_last      <= 1'b1;
            owner        <= 1'b0;
            grant        <= 2'b00;
            SDIO_control <= 1'b0;
            switch_pulse <= 1'b0;
        end else begin
            state        <= state_next;
            guard_cnt    <= guard_cnt_next;
            rr_last      <= rr_last_next;
            owner        <= owner_next;
            grant        <= grant_next;
            switch_pulse <= toggle;
            if (toggle) SDIO_control <= ~SDIO_control;
        end
    end

endmodule

// File: tb/tb_sdio_owner_arbiter.sv
// Directed self-checking bench for sdio_owner_arbiter.
// Scenario tasks run in sequence; every expected value is hand-derived.
module tb_sdio_owner_arbiter;

    logic        pclk;
    logic        presetn;
    logic        psel;
    logic        penable;
    logic [31:0] paddr;
    logic        pwrite;
    logic [31:0] pwdata;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;
    logic [1:0]  req;
    logic        sdio_busy;
    logic [1:0]  grant;
    logic        SDIO_control;
    logic        switch_pulse;

    int          checks;
    int          failures;
    logic [31:0] rd;
    logic        err;
    logic        rdy;

    sdio_owner_arbiter #(.GUARD_DEFAULT(16), .CNT_W(16)) dut (
        .pclk         (pclk),
        .presetn      (presetn),
        .psel         (psel),
        .penable      (penable),
        .paddr        (paddr),
        .pwrite       (pwrite),
        .pwdata       (pwdata),
        .prdata       (prdata),
        .pready       (pready),
        .pslverr      (pslverr),
        .req          (req),
        .sdio_busy    (sdio_busy),
        .grant        (grant),
        .SDIO_control (SDIO_control),
        .switch_pulse (switch_pulse)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    task automatic apb_write(input logic [31:0] addr, input logic [31:0] data);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = addr; pwdata = data;
        tick();
        penable = 1'b1;
        tick();
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    task automatic apb_read(input logic [31:0] addr, output logic [31:0] data,
                            output logic slverr, output logic ready);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = addr;
        tick();
        penable = 1'b1;
        #1;
        data = prdata; slverr = pslverr; ready = pready;
        tick();
        psel = 1'b0; penable = 1'b0;
    endtask

    task automatic test_reset();
        presetn = 1'b0; psel = 1'b0; penable = 1'b0; paddr = '0; pwrite = 1'b0;
        pwdata = '0; req = 2'b00; sdio_busy = 1'b0;
        #3;
        checks++; if (grant !== 2'b00) begin failures++; $display("[TB] FAIL reset_grant got=%b exp=00", grant); end
        checks++; if (SDIO_control !== 1'b0) begin failures++; $display("[TB] FAIL reset_sel got=%b exp=0", SDIO_control); end
        checks++; if (pready !== 1'b0 || prdata !== 32'h0) begin failures++; $display("[TB] FAIL reset_apb got=%b/%h exp=0/0", pready, prdata); end
        tick(); tick();
        presetn = 1'b1;
        tick();
        apb_read(32'h0, rd, err, rdy);
        checks++; if (rd !== 32'h0000_1000) begin failures++; $display("[TB] FAIL reset_ctrl got=%h exp=00001000", rd); end
        checks++; if (rdy !== 1'b1 || err !== 1'b0) begin failures++; $display("[TB] FAIL access_flags got=%b/%b exp=1/0", rdy, err); end
        apb_read(32'h8, rd, err, rdy);
        checks++; if (rd !== 32'h0) begin failures++; $display("[TB] FAIL reset_swcnt got=%h exp=0", rd); end
    endtask

    task automatic test_grant_latency();
        req = 2'b01;
        tick();
        checks++; if (grant !== 2'b00) begin failures++; $display("[TB] FAIL lat_cycle1 got=%b exp=00", grant); end
        tick();
        checks++; if (grant !== 2'b01) begin failures++; $display("[TB] FAIL lat_cycle2 got=%b exp=01", grant); end
        checks++; if (SDIO_control !== 1'b0 || switch_pulse !== 1'b0) begin failures++; $display("[TB] FAIL lat_sel got=%b/%b exp=0/0", SDIO_control, switch_pulse); end
        apb_read(32'h4, rd, err, rdy);
        checks++; if (rd !== 32'h0000_0091) begin failures++; $display("[TB] FAIL status_own got=%h exp=00000091", rd); end
        apb_read(32'h8, rd, err, rdy);
        checks++; if (rd !== 32'h0) begin failures++; $display("[TB] FAIL swcnt_nosw got=%h exp=0", rd); end
    endtask

    task automatic test_guard_switch();
        apb_write(32'h0, 32'h0000_0400);
        req = 2'b00;
        tick();
        req = 2'b10;
        tick();
        checks++; if (SDIO_control !== 1'b1 || switch_pulse !== 1'b1) begin failures++; $display("[TB] FAIL guard_toggle got=%b/%b exp=1/1", SDIO_control, switch_pulse); end
        checks++; if (grant !== 2'b00) begin failures++; $display("[TB] FAIL guard_g0 got=%b exp=00", grant); end
        for (int i = 1; i < 5; i++) begin
            tick();
            checks++; if (grant !== 2'b00 || switch_pulse !== 1'b0) begin failures++; $display("[TB] FAIL guard_hold%0d got=%b/%b exp=00/0", i, grant, switch_pulse); end
        end
        tick();
        checks++; if (grant !== 2'b10) begin failures++; $display("[TB] FAIL guard_grant got=%b exp=10", grant); end
        apb_read(32'h8, rd, err, rdy);
        checks++; if (rd !== 32'h1) begin failures++; $display("[TB] FAIL swcnt_one got=%h exp=1", rd); end
    endtask

    task automatic test_round_robin();
        req = 2'b00;
        tick();
        req = 2'b11;
        tick();
        checks++; if (SDIO_control !== 1'b0) begin failures++; $display("[TB] FAIL rr0_sel got=%b exp=0", SDIO_control); end
        repeat (4) tick();
        tick();
        checks++; if (grant !== 2'b01) begin failures++; $display("[TB] FAIL rr0_grant got=%b exp=01", grant); end
        repeat (3) tick();
        checks++; if (grant !== 2'b01) begin failures++; $display("[TB] FAIL no_preempt got=%b exp=01", grant); end
        req = 2'b00;
        tick();
        req = 2'b11;
        tick();
        checks++; if (SDIO_control !== 1'b1) begin failures++; $display("[TB] FAIL rr1_sel got=%b exp=1", SDIO_control); end
        repeat (4) tick();
        tick();
        checks++; if (grant !== 2'b10) begin failures++; $display("[TB] FAIL rr1_grant got=%b exp=10", grant); end
    endtask

    task automatic test_drain();
        sdio_busy = 1'b1;
        req = 2'b01;
        tick();
        checks++; if (grant !== 2'b00) begin failures++; $display("[TB] FAIL drain_grant got=%b exp=00", grant); end
        apb_read(32'h4, rd, err, rdy);
        checks++; if (rd !== 32'h0000_00DC) begin failures++; $display("[TB] FAIL status_drain got=%h exp=000000dc", rd); end
        for (int i = 0; i < 6; i++) begin
            tick();
            checks++; if (grant !== 2'b00 || SDIO_control !== 1'b1) begin failures++; $display("[TB] FAIL drain_hold%0d got=%b/%b exp=00/1", i, grant, SDIO_control); end
        end
        sdio_busy = 1'b0;
        tick();
        checks++; if (SDIO_control !== 1'b1) begin failures++; $display("[TB] FAIL drain_exit_sel got=%b exp=1", SDIO_control); end
        tick();
        checks++; if (SDIO_control !== 1'b0 || switch_pulse !== 1'b1) begin failures++; $display("[TB] FAIL drain_toggle got=%b/%b exp=0/1", SDIO_control, switch_pulse); end
        repeat (4) tick();
        tick();
        checks++; if (grant !== 2'b01) begin failures++; $display("[TB] FAIL drain_next got=%b exp=01", grant); end
    endtask

    task automatic test_force_and_error();
        req = 2'b00;
        tick();
        apb_write(32'h0, 32'h0000_0003);
        tick();
        checks++; if (SDIO_control !== 1'b1 || switch_pulse !== 1'b1) begin failures++; $display("[TB] FAIL force_toggle got=%b/%b exp=1/1", SDIO_control, switch_pulse); end
        for (int p = 1; p < 4; p++) begin
            req = 2'(p);
            repeat (2) tick();
            checks++; if (grant !== 2'b00 || SDIO_control !== 1'b1) begin failures++; $display("[TB] FAIL force_req%0d got=%b/%b exp=00/1", p, grant, SDIO_control); end
        end
        req = 2'b00;
        apb_read(32'hC, rd, err, rdy);
        checks++; if (err !== 1'b1 || rd !== 32'h0) begin failures++; $display("[TB] FAIL bad_addr got=%b/%h exp=1/0", err, rd); end
        apb_read(32'h0, rd, err, rdy);
        checks++; if (rd !== 32'h0000_0003) begin failures++; $display("[TB] FAIL force_ctrl got=%h exp=00000003", rd); end
        apb_write(32'h0, 32'h0000_0400);
    endtask

    task automatic test_back_to_back();
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h8; pwdata = 32'h0;
        tick();
        penable = 1'b1;
        req = 2'b01;
        tick();
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        checks++; if (SDIO_control !== 1'b0 || switch_pulse !== 1'b1) begin failures++; $display("[TB] FAIL coinc_toggle got=%b/%b exp=0/1", SDIO_control, switch_pulse); end
        apb_read(32'h8, rd, err, rdy);
        checks++; if (rd !== 32'h0) begin failures++; $display("[TB] FAIL coinc_swcnt got=%h exp=0", rd); end
        repeat (2) tick();
        checks++; if (grant !== 2'b00) begin failures++; $display("[TB] FAIL coinc_guard got=%b exp=00", grant); end
        tick();
        checks++; if (grant !== 2'b01) begin failures++; $display("[TB] FAIL coinc_grant got=%b exp=01", grant); end
    endtask

    task automatic test_reset_in_guard();
        req = 2'b00;
        tick();
        req = 2'b10;
        tick();
        tick();
        checks++; if (SDIO_control !== 1'b1 || grant !== 2'b00) begin failures++; $display("[TB] FAIL pre_reset got=%b/%b exp=1/00", SDIO_control, grant); end
        #2;
        presetn = 1'b0;
        #1;
        checks++; if (SDIO_control !== 1'b0 || grant !== 2'b00 || switch_pulse !== 1'b0) begin failures++; $display("[TB] FAIL async_reset got=%b/%b/%b exp=0/00/0", SDIO_control, grant, switch_pulse); end
        req = 2'b00;
        tick(); tick();
        presetn = 1'b1;
        tick();
        apb_read(32'h0, rd, err, rdy);
        checks++; if (rd !== 32'h0000_1000) begin failures++; $display("[TB] FAIL rst_guard got=%h exp=00001000", rd); end
        apb_read(32'h8, rd, err, rdy);
        checks++; if (rd !== 32'h0) begin failures++; $display("[TB] FAIL rst_swcnt got=%h exp=0", rd); end
        apb_read(32'h4, rd, err, rdy);
        checks++; if (rd !== 32'h0) begin failures++; $display("[TB] FAIL rst_status got=%h exp=0", rd); end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_grant_latency();
        test_guard_switch();
        test_round_robin();
        test_drain();
        test_force_and_error();
        test_back_to_back();
        test_reset_in_guard();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
